// File: rtl/plca_148_pkg.sv
// Shared definitions for the PLCA control scheduler: state codes, PCS command
// encodings and timer defaults.
package plca_148_pkg;

  typedef enum logic [3:0] {
    ST_DISABLE     = 4'd0,
    ST_RESYNC      = 4'd1,
    ST_SEND_BEACON = 4'd2,
    ST_SYNCING     = 4'd3,
    ST_WAIT_TO     = 4'd4,
    ST_COMMIT      = 4'd5,
    ST_TRANSMIT    = 4'd6,
    ST_BURST       = 4'd7,
    ST_RECEIVE     = 4'd8,
    ST_YIELD       = 4'd9,
    ST_NEXT_TX_OPP = 4'd10,
    ST_ABORT       = 4'd11
  } plca_state_e;

  // Command encodings shared with the Clause 147 PCS.
  localparam logic [1:0] CMD_NONE      = 2'b00;
  localparam logic [1:0] CMD_COMMIT    = 2'b01;
  localparam logic [1:0] CMD_BEACON    = 2'b10;
  localparam logic [1:0] CMD_HEARTBEAT = 2'b11;

  localparam int DEF_CLK_PER_BIT          = 1;
  localparam int DEF_TO_TIMER             = 32;
  localparam int DEF_BEACON_TIME          = 20;
  localparam int DEF_BURST_TIMER          = 128;
  localparam int DEF_INVALID_BEACON_TIMER = 4000;

  localparam int         TIMER_W     = 12;
  localparam logic [7:0] NODE_ID_OFF = 8'hFF;

endpackage

// File: rtl/plca_control_148_4_timer.sv
// plca_timer: loadable bit-time down-counter. done is high in the last clock of
// the final bit, so a load of N-1 gives a state lifetime of exactly N bit times.
module plca_timer #(
  parameter int W           = 12,
  parameter int CLK_PER_BIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  localparam int PW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  logic [W-1:0]  count_q;
  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == PW'(CLK_PER_BIT - 1));
  assign done = (count_q == '0) && tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      pre_q   <= '0;
    end else if (load) begin
      count_q <= load_val;
      pre_q   <= '0;
    end else if (tick) begin
      pre_q <= '0;
      if (count_q != '0) count_q <= count_q - 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

endmodule

// File: rtl/plca_control_148_4.sv
// PLCA control scheduler: rotates the transmit opportunity on a 10BASE-T1S
// mixing segment. Define PLCA_BURST_EN to enable multi-frame bursts (max_bc).
module plca_control_148_4
  import plca_148_pkg::*;
#(
  parameter int CLK_PER_BIT          = DEF_CLK_PER_BIT,
  parameter int TO_TIMER             = DEF_TO_TIMER,
  parameter int BEACON_TIME          = DEF_BEACON_TIME,
  parameter int BURST_TIMER          = DEF_BURST_TIMER,
  parameter int INVALID_BEACON_TIMER = DEF_INVALID_BEACON_TIMER
) (
  input  logic       clk,
  input  logic       pcs_reset,
  input  logic       plca_en,
  input  logic [7:0] local_nodeID,
  input  logic [7:0] node_count,
  input  logic [7:0] max_bc,
  input  logic       packetPending,
  input  logic       tx_en,
  input  logic       CRS,
  input  logic [1:0] rx_cmd,
  output logic [1:0] tx_cmd,
  output logic       committed,
  output logic [7:0] curID,
  output logic       plca_active,
  output logic [3:0] plca_state
);

  plca_state_e state_q, state_d;
  logic [1:0]  tx_cmd_q, tx_cmd_d;
  logic        committed_q, committed_d;
  logic        active_q, active_d;
  logic [7:0]  cur_id_q, cur_id_d;
  logic        bcn_wait_q, bcn_wait_d;

  logic enabled, is_coord, rx_beacon, own_slot;
  logic to_load, bcn_load, burst_load, ibt_load;
  logic to_done, bcn_done, burst_done, ibt_done;

  assign enabled   = plca_en && (local_nodeID != NODE_ID_OFF);
  assign is_coord  = (local_nodeID == 8'd0);
  assign rx_beacon = (rx_cmd == CMD_BEACON);
  assign own_slot  = (cur_id_q == local_nodeID);

`ifdef PLCA_BURST_EN
  logic [7:0] bc_q, bc_d;
  logic       bc_room;
  assign bc_room = (bc_q < max_bc);
`else
  logic unused_burst;
  assign unused_burst = ^{max_bc, burst_done};
`endif

  // Next-state logic; follower beacon/loss overrides and global disable last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLE:     if (enabled) state_d = is_coord ? ST_SEND_BEACON : ST_RESYNC;
      ST_RESYNC:      if (rx_beacon) state_d = ST_SYNCING;
      ST_SEND_BEACON: if (!bcn_wait_q && bcn_done) state_d = ST_SYNCING;
      ST_SYNCING:     if (is_coord || !rx_beacon) state_d = ST_WAIT_TO;
      ST_WAIT_TO: begin
        if (CRS)                          state_d = ST_RECEIVE;
        else if (own_slot && packetPending) state_d = ST_COMMIT;
        else if (own_slot)                state_d = ST_YIELD;
        else if (to_done)                 state_d = ST_NEXT_TX_OPP;
      end
      ST_YIELD: begin
        if (CRS)          state_d = ST_RECEIVE;
        else if (to_done) state_d = ST_NEXT_TX_OPP;
      end
      ST_COMMIT: begin
        if (tx_en)               state_d = ST_TRANSMIT;
        else if (!packetPending) state_d = ST_ABORT;
      end
      ST_TRANSMIT: begin
        if (!tx_en) begin
`ifdef PLCA_BURST_EN
          state_d = bc_room ? ST_BURST : ST_NEXT_TX_OPP;
`else
          state_d = ST_NEXT_TX_OPP;
`endif
        end
      end
`ifdef PLCA_BURST_EN
      ST_BURST: begin
        if (tx_en)           state_d = ST_TRANSMIT;
        else if (burst_done) state_d = ST_NEXT_TX_OPP;
      end
`endif
      ST_ABORT:   if (!CRS) state_d = ST_NEXT_TX_OPP;
      ST_RECEIVE: if (!CRS) state_d = ST_NEXT_TX_OPP;
      ST_NEXT_TX_OPP: begin
        // cur_id_q already holds the advanced ID while in this state.
        if (is_coord && (cur_id_q >= node_count)) state_d = ST_SEND_BEACON;
        else if (cur_id_q == 8'hFF)               state_d = ST_RESYNC;
        else                                      state_d = ST_WAIT_TO;
      end
      default: state_d = ST_DISABLE;
    endcase

    if (!is_coord && (state_q inside {ST_WAIT_TO, ST_YIELD, ST_COMMIT, ST_BURST,
                                      ST_ABORT, ST_RECEIVE, ST_NEXT_TX_OPP})) begin
      if (rx_beacon)     state_d = ST_SYNCING;
      else if (ibt_done) state_d = ST_RESYNC;
    end

    if (!enabled) state_d = ST_DISABLE;
  end

  // Registered outputs are computed from the state being entered.
  always_comb begin
    tx_cmd_d    = CMD_NONE;
    committed_d = 1'b0;
    active_d    = active_q;
    cur_id_d    = cur_id_q;
    bcn_wait_d  = bcn_wait_q;

    if (state_d == ST_SEND_BEACON && state_q != ST_SEND_BEACON) bcn_wait_d = CRS;
    else if (state_q == ST_SEND_BEACON && !CRS)                 bcn_wait_d = 1'b0;

    case (state_d)
      ST_DISABLE, ST_RESYNC: begin
        active_d = 1'b0;
        cur_id_d = 8'd0;
      end
      ST_SEND_BEACON: begin
        cur_id_d = 8'd0;
        if (!bcn_wait_d) tx_cmd_d = CMD_BEACON;
      end
      ST_SYNCING: begin
        cur_id_d = 8'd0;
        active_d = 1'b1;
      end
      ST_COMMIT, ST_BURST: begin
        tx_cmd_d    = CMD_COMMIT;
        committed_d = 1'b1;
      end
      ST_TRANSMIT:    committed_d = 1'b1;
      ST_NEXT_TX_OPP: cur_id_d = cur_id_q + 8'd1;
      default: ;
    endcase
  end

  assign to_load  = (state_d == ST_WAIT_TO) && (state_q != ST_WAIT_TO);
  // While carrier holds off the beacon, keep the beacon timer parked at full.
  assign bcn_load = ((state_d == ST_SEND_BEACON) && (state_q != ST_SEND_BEACON)) ||
                    ((state_q == ST_SEND_BEACON) && bcn_wait_q);
  assign ibt_load = (state_q == ST_SYNCING) || (state_d == ST_SYNCING);
`ifdef PLCA_BURST_EN
  assign burst_load = (state_d == ST_BURST) && (state_q != ST_BURST);
`else
  assign burst_load = 1'b0;
`endif

  always_ff @(posedge clk or posedge pcs_reset) begin
    if (pcs_reset) begin
      state_q     <= ST_DISABLE;
      tx_cmd_q    <= CMD_NONE;
      committed_q <= 1'b0;
      active_q    <= 1'b0;
      cur_id_q    <= 8'd0;
      bcn_wait_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_cmd_q    <= tx_cmd_d;
      committed_q <= committed_d;
      active_q    <= active_d;
      cur_id_q    <= cur_id_d;
      bcn_wait_q  <= bcn_wait_d;
    end
  end

`ifdef PLCA_BURST_EN
  always_comb begin
    bc_d = bc_q;
    if (state_d == ST_COMMIT)                                bc_d = 8'd0;
    else if (state_q == ST_TRANSMIT && state_d == ST_BURST)  bc_d = bc_q + 8'd1;
  end

  always_ff @(posedge clk or posedge pcs_reset) begin
    if (pcs_reset) bc_q <= 8'd0;
    else           bc_q <= bc_d;
  end
`endif

  plca_timer #(.W(TIMER_W), .CLK_PER_BIT(CLK_PER_BIT)) u_to_timer (
    .clk(clk), .rst(pcs_reset), .load(to_load),
    .load_val(TIMER_W'(TO_TIMER - 1)), .done(to_done));

  plca_timer #(.W(TIMER_W), .CLK_PER_BIT(CLK_PER_BIT)) u_beacon_timer (
    .clk(clk), .rst(pcs_reset), .load(bcn_load),
    .load_val(TIMER_W'(BEACON_TIME - 1)), .done(bcn_done));

  plca_timer #(.W(TIMER_W), .CLK_PER_BIT(CLK_PER_BIT)) u_burst_timer (
    .clk(clk), .rst(pcs_reset), .load(burst_load),
    .load_val(TIMER_W'(BURST_TIMER - 1)), .done(burst_done));

  plca_timer #(.W(TIMER_W), .CLK_PER_BIT(CLK_PER_BIT)) u_invalid_beacon_timer (
    .clk(clk), .rst(pcs_reset), .load(ibt_load),
    .load_val(TIMER_W'(INVALID_BEACON_TIMER - 1)), .done(ibt_done));

  assign tx_cmd      = tx_cmd_q;
  assign committed   = committed_q;
  assign curID       = cur_id_q;
  assign plca_active = active_q;
  assign plca_state  = state_q;

endmodule
